// File: rtl/bayer_quad_assembler.sv
// rtl/bayer_quad_assembler.sv - groups raster RGGB Bayer pixels into {R,G1,G2,B} quad words
// Even-row R/G pairs wait in a half-width line buffer until the matching odd-row G/B pair arrives.
module bayer_quad_assembler #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_pixel,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        frame_done
);

  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int COL_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int ROW_W  = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(HALF_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST_PAIR = ROW_W'(IMG_HEIGHT - 2);

  typedef enum logic [1:0] {
    EVEN_R  = 2'd0,
    EVEN_G1 = 2'd1,
    ODD_G2  = 2'd2,
    ODD_B   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_nxt;
  logic [7:0]       r_hold;
  logic [7:0]       g2_hold;
  logic [15:0]      line_buf [HALF_W];
  logic [15:0]      line_rd;

  logic in_xfer;
  logic out_xfer;
  logic col_last;
  logic row_last;
  logic lb_we;
  logic quad_load;

  // Only a B pixel can overwrite a waiting quad, so that is the one pixel we must stall.
  assign in_ready = !((state == ODD_B) && out_valid && !out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST_PAIR);
  assign line_rd  = line_buf[col];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EVEN_R;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    lb_we     = 1'b0;
    quad_load = 1'b0;
    if (in_xfer) begin
      if (in_sof) begin
        // Start-of-frame pixel is always R at row 0, col 0; any partial quad is abandoned.
        state_nxt = EVEN_G1;
        col_nxt   = '0;
        row_nxt   = '0;
      end else begin
        case (state)
          EVEN_R: state_nxt = EVEN_G1;
          EVEN_G1: begin
            lb_we = 1'b1;
            if (col_last) begin
              col_nxt   = '0;
              state_nxt = ODD_G2;
            end else begin
              col_nxt   = col + COL_W'(1);
              state_nxt = EVEN_R;
            end
          end
          ODD_G2: state_nxt = ODD_B;
          ODD_B: begin
            quad_load = 1'b1;
            if (col_last) begin
              col_nxt   = '0;
              row_nxt   = row_last ? '0 : row + ROW_W'(2);
              state_nxt = EVEN_R;
            end else begin
              col_nxt   = col + COL_W'(1);
              state_nxt = ODD_G2;
            end
          end
          default: state_nxt = EVEN_R;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold  <= '0;
      g2_hold <= '0;
    end else if (in_xfer) begin
      if (in_sof || (state == EVEN_R)) begin
        r_hold <= in_pixel;
      end
      if (!in_sof && (state == ODD_G2)) begin
        g2_hold <= in_pixel;
      end
    end
  end

  // Line buffer is deliberately left unreset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf[col] <= {r_hold, in_pixel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (quad_load) begin
        out_valid  <= 1'b1;
        out_data   <= {line_rd, g2_hold, in_pixel};
        frame_done <= col_last && row_last;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bayer_quad_assembler.sv
// tb/tb_bayer_quad_assembler.sv - self-checking bench for bayer_quad_assembler
// Reference model tracks raster (x,y) position and a frame image; quads fall out of the image directly.
module tb_bayer_quad_assembler;

  localparam int WID [2] = '{4, 8};
  localparam int HGT [2] = '{2, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [2];
  logic        in_sof    [2];
  logic [7:0]  in_pixel  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] out_data  [2];
  logic        out_ready [2];
  logic        frame_done[2];

  always #5 clk = ~clk;

  bayer_quad_assembler #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) u_dut_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_sof(in_sof[0]), .in_pixel(in_pixel[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .frame_done(frame_done[0])
  );

  bayer_quad_assembler #(.IMG_WIDTH(8), .IMG_HEIGHT(4)) u_dut_wide (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_sof(in_sof[1]), .in_pixel(in_pixel[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .frame_done(frame_done[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int          px [2];
  int          py [2];
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  logic        m_fd    [2];
  logic [7:0]  img [2][4][8];
  logic        m_ix, m_ox, m_load;

  function automatic logic exp_ready(input int s);
    return !((py[s] % 2 == 1) && (px[s] % 2 == 1) && m_valid[s] && !out_ready[s]);
  endfunction

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        px[s] = 0; py[s] = 0;
        m_valid[s] = 1'b0; m_data[s] = '0; m_fd[s] = 1'b0;
      end else begin
        m_ix   = in_valid[s] && exp_ready(s);
        m_ox   = m_valid[s] && out_ready[s];
        m_load = 1'b0;
        m_fd[s] = 1'b0;
        if (m_ix) begin
          if (in_sof[s]) begin
            px[s] = 0; py[s] = 0;
          end
          img[s][py[s]][px[s]] = in_pixel[s];
          if ((py[s] % 2 == 1) && (px[s] % 2 == 1)) begin
            m_load  = 1'b1;
            m_data[s] = {img[s][py[s]-1][px[s]-1], img[s][py[s]-1][px[s]],
                         img[s][py[s]][px[s]-1], in_pixel[s]};
            m_fd[s] = (py[s] == HGT[s] - 1) && (px[s] == WID[s] - 1);
          end
          px[s]++;
          if (px[s] == WID[s]) begin
            px[s] = 0;
            py[s]++;
            if (py[s] == HGT[s]) py[s] = 0;
          end
        end
        if (m_load) m_valid[s] = 1'b1;
        else if (m_ox) m_valid[s] = 1'b0;
      end
    end
  end

  logic [31:0] got0 [$];
  int          got1_cnt;
  int          fd_cnt [2];

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (chk_en) begin
        check($sformatf("in_ready[%0d]", s),   32'(in_ready[s]),   32'(exp_ready(s)));
        check($sformatf("out_valid[%0d]", s),  32'(out_valid[s]),  32'(m_valid[s]));
        check($sformatf("out_data[%0d]", s),   out_data[s],        m_data[s]);
        check($sformatf("frame_done[%0d]", s), 32'(frame_done[s]), 32'(m_fd[s]));
        if (out_valid[s] && out_ready[s]) begin
          if (s == 0) got0.push_back(out_data[s]);
          else got1_cnt++;
        end
        if (frame_done[s]) fd_cnt[s]++;
      end
    end
  end

  logic ready_force [2];
  bit   rand_rdy = 1'b0;

  initial begin
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++)
        out_ready[s] = rand_rdy ? ($urandom_range(0, 3) != 0) : ready_force[s];
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [7:0] p, input logic sof);
    in_valid[s] = 1'b1;
    in_pixel[s] = p;
    in_sof[s]   = sof;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready[s]) begin
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
        in_sof[s]   = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout: inst %0d pixel %h never accepted, required acceptance within 500 cycles", s, p);
    in_valid[s] = 1'b0;
    in_sof[s]   = 1'b0;
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got0.size() > i) ? got0[i] : 32'hDEAD_BEEF;
  endfunction

  logic [7:0] frame_a [8] = '{8'h0A, 8'h14, 8'h1E, 8'h28, 8'h32, 8'h3C, 8'h46, 8'h50};

  initial begin
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; in_sof[s] = 1'b0; in_pixel[s] = '0;
      ready_force[s] = 1'b1; fd_cnt[s] = 0;
    end
    got1_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_in_ready[%0d]", s),  32'(in_ready[s]),   32'd1);
      check($sformatf("rst_out_valid[%0d]", s), 32'(out_valid[s]),  32'd0);
      check($sformatf("rst_out_data[%0d]", s),  out_data[s],        32'h0);
      check($sformatf("rst_fd[%0d]", s),        32'(frame_done[s]), 32'd0);
    end
    chk_en = 1'b1;
    idle(1);

    // Basic frame with one-cycle latency
    got0.delete(); fd_cnt[0] = 0;
    for (int i = 0; i < 6; i++) send(0, frame_a[i], i == 0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid[0]), 32'd1);
    check("lat_data", out_data[0], 32'h0A14323C);
    @(posedge clk); #1;
    for (int i = 6; i < 8; i++) send(0, frame_a[i], 1'b0);
    idle(3);
    check("basic_count", 32'(got0.size()), 32'd2);
    check("basic_q0", got_at(0), 32'h0A14323C);
    check("basic_q1", got_at(1), 32'h1E284650);
    check("basic_fd", 32'(fd_cnt[0]), 32'd1);

    // Backpressure: B pixel stalls while the first quad waits
    got0.delete();
    ready_force[0] = 1'b0;
    idle(1);
    for (int i = 0; i < 7; i++) send(0, frame_a[i], i == 0);
    fork
      send(0, frame_a[7], 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        check("bp_hold", out_data[0], 32'h0A14323C);
        ready_force[0] = 1'b1;
      end
    join
    idle(3);
    check("bp_count", 32'(got0.size()), 32'd2);
    check("bp_q0", got_at(0), 32'h0A14323C);
    check("bp_q1", got_at(1), 32'h1E284650);

    // Resync on a mid-row start of frame
    got0.delete();
    send(0, 8'h10, 1'b1); send(0, 8'h20, 1'b0); send(0, 8'h50, 1'b0);
    send(0, 8'h11, 1'b1); send(0, 8'h22, 1'b0); send(0, 8'hAA, 1'b0); send(0, 8'hBB, 1'b0);
    send(0, 8'h33, 1'b0); send(0, 8'h44, 1'b0); send(0, 8'hCC, 1'b0); send(0, 8'hDD, 1'b0);
    idle(3);
    check("sync_count", 32'(got0.size()), 32'd2);
    check("sync_q0", got_at(0), 32'h11223344);
    check("sync_q1", got_at(1), 32'hAABBCCDD);

    // Reset while a quad is held under backpressure
    ready_force[0] = 1'b0;
    idle(1);
    for (int i = 0; i < 6; i++) send(0, frame_a[i], i == 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    check("mid_rst_data", out_data[0], 32'h0);
    check("mid_rst_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    ready_force[0] = 1'b1;
    idle(1);
    got0.delete();
    for (int i = 1; i <= 8; i++) send(0, 8'(i), i == 1);
    idle(3);
    check("post_rst_q0", got_at(0), 32'h01020506);
    check("post_rst_q1", got_at(1), 32'h03040708);

    // Saturated pixels over two frames, the second relying on row wrap
    got0.delete(); fd_cnt[0] = 0;
    for (int i = 0; i < 16; i++) send(0, 8'hFF, i == 0);
    idle(3);
    check("max_count", 32'(got0.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("max_q%0d", i), got_at(i), 32'hFFFFFFFF);
    check("max_fd", 32'(fd_cnt[0]), 32'd2);

    // Wide instance, gapless full frame
    got1_cnt = 0; fd_cnt[1] = 0;
    for (int i = 0; i < 32; i++) send(1, 8'($urandom), i == 0);
    idle(3);
    check("wide_count", 32'(got1_cnt), 32'd8);
    check("wide_fd", 32'(fd_cnt[1]), 32'd1);

    // Randomized traffic with random backpressure, occasional resync and one reset
    rand_rdy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if (n == 150) begin
          rst = 1'b1;
          idle(1);
          rst = 1'b0;
        end
        send(s, 8'($urandom), $urandom_range(0, 40) == 0);
      end
    end
    rand_rdy = 1'b0;
    ready_force[0] = 1'b1;
    ready_force[1] = 1'b1;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
